// File: rtl/i2c_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : i2c_reg_ctrl
// Brief   : Register bank behind an I2C subordinate: pointer byte, auto-increment
//           burst write/read, and a host port that yields to I2C writes.
// Rev     : 1.0
// ============================================================================
module i2c_reg_ctrl #(
    parameter int                  NUM_REGS  = 16,
    parameter int                  PTR_W     = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter int                  MAX_BURST = 8
) (
    input  logic             clk_400,
    input  logic             rst,
    input  logic             sub_busy,
    input  logic             sub_rw,
    input  logic             sub_data_ready,
    input  logic [7:0]       sub_data_out,
    input  logic             sub_byte_req,
    input  logic             sub_done,
    output logic [7:0]       sub_data_in,
    output logic             sub_next_byte,
    input  logic             host_wr_en,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic             host_collision,
    output logic             ro_err,
    output logic             active
);

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PTR   = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam logic [7:0] c_last_cnt = 8'(MAX_BURST - 1);

    state_t           state_q, state_d;
    logic [7:0]       regs_q [NUM_REGS];
    logic [7:0]       regs_d [NUM_REGS];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       sub_data_in_q, sub_data_in_d;
    logic             busy_prev_q;
    logic             wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic             host_collision_q, host_collision_d;
    logic             ro_err_q, ro_err_d;

    logic             w_busy_rise;
    logic             w_in_xfer;
    logic [PTR_W-1:0] w_ptr_inc;

    assign w_busy_rise = sub_busy & ~busy_prev_q;
    assign w_in_xfer   = (state_q == ST_PTR) || (state_q == ST_WRITE) || (state_q == ST_READ);
    assign w_ptr_inc   = ptr_q + 1'b1;

    generate
        if (PTR_W < 8) begin : g_unused_ptr_bits
            logic unused_ptr_bits;
            assign unused_ptr_bits = ^sub_data_out[7:PTR_W];
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        regs_d           = regs_q;
        ptr_d            = ptr_q;
        cnt_d            = cnt_q;
        sub_data_in_d    = sub_data_in_q;
        ro_err_d         = ro_err_q;
        wr_strobe_d      = 1'b0;
        wr_addr_d        = wr_addr_q;
        host_collision_d = 1'b0;

        case (state_q)
            ST_SYNC: begin
                if (!sub_busy) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_busy_rise) begin
                    cnt_d = '0;
                    if (sub_rw) begin
                        state_d       = ST_READ;
                        sub_data_in_d = regs_q[ptr_q];
                    end else begin
                        state_d = ST_PTR;
                    end
                end
            end
            ST_PTR: begin
                if (sub_data_ready) begin
                    ptr_d   = sub_data_out[PTR_W-1:0];
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (sub_data_ready) begin
                    if (!RO_MASK[ptr_q]) begin
                        regs_d[ptr_q] = sub_data_out;
                        wr_strobe_d   = 1'b1;
                        wr_addr_d     = ptr_q;
                    end else begin
                        ro_err_d = 1'b1;
                    end
                    ptr_d = w_ptr_inc;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            ST_READ: begin
                // Prefetch: the byte for the next request is loaded now.
                if (sub_byte_req) begin
                    sub_data_in_d = regs_q[w_ptr_inc];
                    ptr_d         = w_ptr_inc;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        // A byte arriving with the end of transfer is handled above first.
        if (w_in_xfer && (sub_done || !sub_busy)) state_d = ST_IDLE;

        if (host_wr_en) begin
            if (wr_strobe_d && (host_addr == ptr_q)) begin
                host_collision_d = 1'b1;
            end else begin
                regs_d[host_addr] = host_wdata;
            end
        end
    end

    always_ff @(posedge clk_400) begin
        if (rst) begin
            state_q          <= ST_SYNC;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            ptr_q            <= '0;
            cnt_q            <= '0;
            sub_data_in_q    <= '0;
            busy_prev_q      <= 1'b0;
            wr_strobe_q      <= 1'b0;
            wr_addr_q        <= '0;
            host_collision_q <= 1'b0;
            ro_err_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            regs_q           <= regs_d;
            ptr_q            <= ptr_d;
            cnt_q            <= cnt_d;
            sub_data_in_q    <= sub_data_in_d;
            busy_prev_q      <= sub_busy;
            wr_strobe_q      <= wr_strobe_d;
            wr_addr_q        <= wr_addr_d;
            host_collision_q <= host_collision_d;
            ro_err_q         <= ro_err_d;
        end
    end

    always_comb begin
        sub_next_byte = 1'b0;
        case (state_q)
            ST_PTR:            sub_next_byte = 1'b1;
            ST_WRITE, ST_READ: sub_next_byte = (cnt_q < c_last_cnt);
            default:           sub_next_byte = 1'b0;
        endcase
    end

    assign sub_data_in    = sub_data_in_q;
    assign host_rdata     = regs_q[host_addr];
    assign wr_strobe      = wr_strobe_q;
    assign wr_addr        = wr_addr_q;
    assign host_collision = host_collision_q;
    assign ro_err         = ro_err_q;
    assign active         = w_in_xfer;

endmodule
`default_nettype wire

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
Register-bank controller behind the I2C subordinate. It turns the subordinate's byte stream into register-pointer and register read/write operations, and it drives the subordinate's data_in and next_byte. The first byte of a write transfer sets the register pointer. Later bytes write registers with pointer auto-increment. Read transfers stream registers starting at the current pointer. A local host port shares the bank, and I2C writes take priority over host writes.

Parameters:
NUM_REGS, 16, number of 8-bit registers; must be a power of two, 2..256
PTR_W, 4, pointer width, equal to log2(NUM_REGS)
RO_MASK, 16'h0000, bit i set means register i is read-only from I2C
MAX_BURST, 8, data bytes per transfer (pointer byte excluded); range 1..255

Ports:
clk_400  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous reset, active-high
sub_busy  in  1  subordinate is in a transfer (addressed)
sub_rw  in  1  transfer direction; sampled on the sub_busy rising edge; 1 = master reads
sub_data_ready  in  1  one-cycle pulse: sub_data_out holds a received byte
sub_data_out  in  8  byte received by the subordinate
sub_byte_req  in  1  one-cycle pulse: subordinate needs the next byte to send
sub_done  in  1  one-cycle pulse: STOP seen, transfer finished
sub_data_in  out  8  byte for the subordinate to transmit
sub_next_byte  out  1  1 = ACK and continue; 0 = last byte, go to STOP
host_wr_en  in  1  host register write strobe
host_addr  in  PTR_W  host register address (read and write)
host_wdata  in  8  host write data
host_rdata  out  8  combinational read: reg[host_addr]
wr_strobe  out  1  one-cycle pulse on every register write accepted from I2C
wr_addr  out  PTR_W  register written, valid with wr_strobe
host_collision  out  1  one-cycle pulse: host write dropped
ro_err  out  1  sticky; set by an I2C write to a read-only register; cleared only by rst
active  out  1  high in PTR, WRITE and READ

Behaviour:
- Reset values: all registers 0, ptr 0, state SYNC, sub_data_in 0, and every output pulse or flag 0. rst in mid-transfer aborts the transfer immediately, and the current transfer is ignored.
- Reset, state SYNC: wait for sub_busy=0, then go to IDLE. This stops the block joining a transfer partway through.
- State IDLE: on the sub_busy rising edge (previous sample 0, current 1), clear the byte counter cnt. If sub_rw=0, go to PTR. If sub_rw=1, go to READ and, in the same transition, load sub_data_in <= reg[ptr].
- State PTR: on sub_data_ready, set ptr <= sub_data_out[PTR_W-1:0]; upper bits are ignored. Then go to WRITE. A PTR byte writes no register.
- State WRITE: on each sub_data_ready:
  - If RO_MASK[ptr]=0: write reg[ptr], pulse wr_strobe with wr_addr=ptr the next cycle.
  - If RO_MASK[ptr]=1: drop the data and set ro_err.
  - In both cases: ptr <= ptr+1 (wraps mod NUM_REGS) and cnt <= cnt+1.
- State READ: sub_data_in is always registered. On each sub_byte_req, sub_data_in <= reg[ptr+1], ptr <= ptr+1 and cnt <= cnt+1. The byte for request N is therefore loaded before request N arrives. Latency from the sub_byte_req pulse to the new sub_data_in is 1 cycle.
- sub_next_byte:
  - 1 in PTR.
  - In WRITE and READ, 1 while cnt < MAX_BURST-1 and 0 once cnt >= MAX_BURST-1, so the last allowed byte is flagged as last.
  - 0 in IDLE and SYNC.
- Transfer end: sub_done, or sub_busy falling, returns PTR, WRITE or READ to IDLE. The pointer is retained, so a later read transfer continues from it.
  - If sub_data_ready and sub_done arrive in the same cycle, the byte is processed first and the state still goes to IDLE.
- Host port: a host write updates reg[host_addr] when no I2C write is accepted that cycle.
  - I2C write and host write in the same cycle to the same address: the I2C data is stored and host_collision pulses.
  - Same cycle, different addresses: both writes are stored.
  - The host port ignores RO_MASK.
- Ignored inputs: sub_byte_req in WRITE and sub_data_ready in READ have no effect.

Test Plan:
- Reset, then a write: busy rise with rw=0, bytes 8'h03, 8'hA5, 8'h5A, then done -> reg3=A5 and reg4=5A; wr_strobe pulses twice with wr_addr 3 then 4; ptr=5; state IDLE.
- Read after that write: busy rise with rw=1 -> sub_data_in=8'h00 (reg5) before the first req; next_byte=1 for the first 7 bytes and 0 for the 8th (MAX_BURST=8); bytes return reg5..reg12.
- Pointer wrap: ptr byte 8'hFF (NUM_REGS=16 -> ptr 15), then write 11, 22 -> reg15=11 and reg0=22.
- RO_MASK=16'h0004: I2C write of 8'h77 to reg2 -> reg2 unchanged, ro_err=1, no wr_strobe; a host write of reg2=8'h77 then succeeds.
- Collision: host_wr_en to reg6 with 8'h11 in the same cycle as an I2C write of 8'h99 to reg6 -> reg6=99 and host_collision pulses once.
- rst pulsed mid-write while sub_busy=1 -> state SYNC; the remaining bytes of that transfer are ignored; normal operation resumes after sub_busy falls and rises again.
